// File: rtl/two_phase_rx_fifo_if.sv
// rtl/two_phase_rx_fifo_if.sv - two-phase req/ack ingress and valid/ready egress bundle
interface two_phase_rx_fifo_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
);
   logic                     req;
   logic [WIDTH-1:0]         din;
   logic                     ack;
   logic [WIDTH-1:0]         dout;
   logic                     dout_valid;
   logic                     dout_ready;
   logic [$clog2(DEPTH):0]   level;
   logic [15:0]              accepted_cnt;

   modport master (
      output req, din, dout_ready,
      input  ack, dout, dout_valid, level, accepted_cnt
   );

   modport slave (
      input  req, din, dout_ready,
      output ack, dout, dout_valid, level, accepted_cnt
   );
endinterface

// File: rtl/two_phase_rx_fifo.sv
// rtl/two_phase_rx_fifo.sv - two-phase bundled-data receiver feeding a FWFT FIFO
// Optional accepted-word counter: TWO_PHASE_RX_FIFO_STATS_EN
module two_phase_rx_fifo #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input logic                  clk,
   input logic                  rst_async_n,
   two_phase_rx_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_ph;
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [WIDTH-1:0]       r_mem [DEPTH];

   logic                   w_req_s;
   logic [PW-1:0]          w_level;
   logic                   w_capture;
   logic                   w_pop;

   assign w_req_s   = r_sync[SYNC_STAGES-1];
   assign w_level   = r_wr_ptr - r_rd_ptr;
   // Full is judged on the pre-pop level, so a same-edge pop never frees a slot for capture
   assign w_capture = (w_req_s != r_ph) && (w_level != FULL_LVL);
   assign w_pop     = (w_level != '0) && bus.dout_ready;

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_sync   <= '0;
         r_ph     <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req};
         if (w_capture) begin
            r_ph     <= ~r_ph;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_mem[r_wr_ptr[AW-1:0]] <= bus.din;
      end
   end

   assign bus.ack        = r_ph;
   assign bus.level      = w_level;
   assign bus.dout_valid = (w_level != '0);
   assign bus.dout       = (w_level != '0) ? r_mem[r_rd_ptr[AW-1:0]] : '0;

`ifdef TWO_PHASE_RX_FIFO_STATS_EN
   logic [15:0] r_acc_cnt;

   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) begin
         r_acc_cnt <= '0;
      end else if (w_capture) begin
         r_acc_cnt <= r_acc_cnt + 16'd1;
      end
   end

   assign bus.accepted_cnt = r_acc_cnt;
`else
   assign bus.accepted_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_two_phase_rx_fifo.sv
// tb/tb_two_phase_rx_fifo.sv - randomized self-checking bench for two_phase_rx_fifo
module tb_two_phase_rx_fifo;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic clk;
   logic rst_async_n;
   int   vectors;
   int   miscompares;
   logic [WIDTH-1:0] exp_q[$];

   two_phase_rx_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   two_phase_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .rst_async_n (rst_async_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      @(negedge clk);
      bus.req        = 1'b0;
      bus.dout_ready = 1'b0;
      rst_async_n    = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_async_n = 1'b1;
   endtask

   task automatic push(input logic [WIDTH-1:0] w, input int budget, output bit ok);
      @(negedge clk);
      bus.din = w;
      bus.req = ~bus.req;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.ack === bus.req) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      vectors++;
      if (bus.ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got=%b exp=0", bus.ack); end
      vectors++;
      if (bus.level !== 3'd0) begin miscompares++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
      vectors++;
      if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.dout_valid); end
      vectors++;
      if (bus.dout !== 32'h0) begin miscompares++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
      vectors++;
      if (bus.accepted_cnt !== 16'h0) begin miscompares++; $display("FAIL reset_cnt got=%h exp=0", bus.accepted_cnt); end
   endtask

   task automatic test_single_word();
      int n;
      bit seen;
      @(negedge clk);
      bus.din = 32'h1234_5678;
      bus.req = 1'b1;
      n = 0;
      seen = 1'b0;
      while (n < 10 && !seen) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.ack === 1'b1) seen = 1'b1;
      end
      vectors++;
      if (!seen || n != SYNC + 1) begin miscompares++; $display("FAIL single_latency got=%0d exp=%0d", n, SYNC + 1); end
      vectors++;
      if (bus.dout_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got=%b exp=1", bus.dout_valid); end
      vectors++;
      if (bus.dout !== 32'h1234_5678) begin miscompares++; $display("FAIL single_dout got=%h exp=12345678", bus.dout); end
      vectors++;
      if (bus.level !== 3'd1) begin miscompares++; $display("FAIL single_level got=%0d exp=1", bus.level); end
      @(negedge clk);
      bus.dout_ready = 1'b1;
      @(negedge clk);
      bus.dout_ready = 1'b0;
      vectors++;
      if (bus.level !== 3'd0) begin miscompares++; $display("FAIL single_drain got=%0d exp=0", bus.level); end
   endtask

   task automatic test_fill();
      bit ok;
      logic [WIDTH-1:0] e;
      bus.dout_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         push(32'hA0 + i, 20, ok);
         exp_q.push_back(32'hA0 + i);
         vectors++;
         if (!ok) begin miscompares++; $display("FAIL fill_ack idx=%0d got=timeout exp=toggle", i); end
      end
      @(negedge clk);
      bus.din = 32'hA0 + DEPTH;
      bus.req = ~bus.req;
      repeat (6) @(negedge clk);
      vectors++;
      if (bus.ack === bus.req) begin miscompares++; $display("FAIL fill_stall got=ack_toggled exp=held"); end
      vectors++;
      if (bus.level !== 3'(DEPTH)) begin miscompares++; $display("FAIL fill_level got=%0d exp=%0d", bus.level, DEPTH); end
      vectors++;
      if (bus.dout !== exp_q[0]) begin miscompares++; $display("FAIL fill_head got=%h exp=%h", bus.dout, exp_q[0]); end
      bus.dout_ready = 1'b1;
      void'(exp_q.pop_front());
      exp_q.push_back(32'hA0 + DEPTH);
      @(negedge clk);
      bus.dout_ready = 1'b0;
      vectors++;
      if (bus.level !== 3'(DEPTH - 1) || bus.ack === bus.req) begin
         miscompares++; $display("FAIL fill_pop_edge got=level%0d ack%b exp=level%0d held", bus.level, bus.ack, DEPTH - 1);
      end
      @(negedge clk);
      vectors++;
      if (bus.level !== 3'(DEPTH) || bus.ack !== bus.req) begin
         miscompares++; $display("FAIL fill_late_capture got=level%0d ack%b exp=level%0d ack%b", bus.level, bus.ack, DEPTH, bus.req);
      end
      bus.dout_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         e = exp_q.pop_front();
         vectors++;
         if (bus.dout !== e) begin miscompares++; $display("FAIL fill_drain idx=%0d got=%h exp=%h", i, bus.dout, e); end
         @(negedge clk);
      end
      bus.dout_ready = 1'b0;
   endtask

   task automatic test_streaming();
      int got;
      bit ok;
      apply_reset();
      bus.dout_ready = 1'b1;
      got = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               exp_q.push_back(i);
               push(i, 40, ok);
               if (!ok) begin vectors++; miscompares++; $display("FAIL stream_ack idx=%0d got=timeout exp=toggle", i); end
               repeat ($urandom_range(0, 2)) @(negedge clk);
            end
         end
         begin
            for (int c = 0; c < 3000 && got < 100; c++) begin
               @(negedge clk);
               if (bus.dout_valid === 1'b1) begin
                  vectors++;
                  if (exp_q.size() == 0 || bus.dout !== exp_q[0]) begin
                     miscompares++; $display("FAIL stream_order idx=%0d got=%h exp=%0d", got, bus.dout, got);
                  end
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  got++;
               end
            end
         end
      join
      vectors++;
      if (got != 100) begin miscompares++; $display("FAIL stream_count got=%0d exp=100", got); end
      repeat (4) @(negedge clk);
      vectors++;
      if (bus.dout_valid !== 1'b0) begin miscompares++; $display("FAIL stream_dup got=valid exp=empty"); end
`ifdef TWO_PHASE_RX_FIFO_STATS_EN
      vectors++;
      if (bus.accepted_cnt !== 16'd100) begin miscompares++; $display("FAIL stream_cnt got=%0d exp=100", bus.accepted_cnt); end
`else
      vectors++;
      if (bus.accepted_cnt !== 16'd0) begin miscompares++; $display("FAIL stream_cnt got=%0d exp=0", bus.accepted_cnt); end
`endif
      bus.dout_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int got;
      int total;
      bit ok;
      logic [WIDTH-1:0] w;
      total = 3 * DEPTH + 1;
      got = 0;
      fork
         begin
            for (int i = 0; i < total; i++) begin
               w = $urandom;
               exp_q.push_back(w);
               push(w, 200, ok);
               if (!ok) begin vectors++; miscompares++; $display("FAIL wrap_ack idx=%0d got=timeout exp=toggle", i); end
            end
         end
         begin
            for (int c = 0; c < 4000 && got < total; c++) begin
               @(negedge clk);
               bus.dout_ready = ($urandom_range(0, 3) == 0);
               vectors++;
               if (bus.level > 3'(DEPTH)) begin miscompares++; $display("FAIL wrap_level got=%0d exp<=%0d", bus.level, DEPTH); end
               if (bus.dout_valid === 1'b1 && bus.dout_ready) begin
                  vectors++;
                  if (exp_q.size() == 0 || bus.dout !== exp_q[0]) begin
                     miscompares++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", got, bus.dout, exp_q.size() ? exp_q[0] : 'x);
                  end
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
                  got++;
               end
            end
         end
      join
      vectors++;
      if (got != total) begin miscompares++; $display("FAIL wrap_count got=%0d exp=%0d", got, total); end
      @(negedge clk);
      bus.dout_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int i = 0; i < 3; i++) push($urandom, 20, ok);
      @(negedge clk);
      bus.req = ~bus.req;
      @(negedge clk);
      vectors++;
      if (bus.level !== 3'd3) begin miscompares++; $display("FAIL mid_prelevel got=%0d exp=3", bus.level); end
      #1;
      rst_async_n = 1'b0;
      bus.req     = 1'b0;
      #1;
      vectors++;
      if (bus.ack !== 1'b0 || bus.level !== 3'd0 || bus.dout_valid !== 1'b0) begin
         miscompares++; $display("FAIL mid_async got=ack%b level%0d valid%b exp=0/0/0", bus.ack, bus.level, bus.dout_valid);
      end
      #18;
      rst_async_n = 1'b1;
      exp_q.delete();
      repeat (6) @(negedge clk);
      vectors++;
      if (bus.level !== 3'd0 || bus.ack !== 1'b0) begin
         miscompares++; $display("FAIL mid_no_capture got=level%0d ack%b exp=0/0", bus.level, bus.ack);
      end
   endtask

`ifdef TWO_PHASE_RX_FIFO_STATS_EN
   task automatic test_cnt_wrap();
      bit ok;
      apply_reset();
      @(negedge clk);
      force dut.r_acc_cnt = 16'hFFFF;
      #1;
      release dut.r_acc_cnt;
      push(32'hC0DE, 20, ok);
      vectors++;
      if (bus.accepted_cnt !== 16'h0000) begin miscompares++; $display("FAIL cnt_wrap got=%h exp=0000", bus.accepted_cnt); end
   endtask
`endif

   initial begin
      vectors        = 0;
      miscompares    = 0;
      bus.req        = 1'b0;
      bus.din        = '0;
      bus.dout_ready = 1'b0;
      rst_async_n    = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_async_n = 1'b1;
      @(negedge clk);
      test_single_word();
      test_fill();
      test_streaming();
      test_wrap();
      test_reset_mid();
`ifdef TWO_PHASE_RX_FIFO_STATS_EN
      test_cnt_wrap();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/two_phase_rx_fifo.md
Name: two_phase_rx_fifo

Overview:
- Downstream consumer of the fetch pipeline's instruction-register stage.
- Accepts bundled-data words on a two-phase req/ack channel and synchronises req into the clock domain.
- Buffers the words in a small FIFO and presents them to a clocked decode stage over valid/ready.
- This is the boundary between the self-timed fetch loop and the first synchronous logic.

Parameters:
- WIDTH, 32, data word width (instruction width).
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- SYNC_STAGES, 2, flip-flops in the req synchroniser; minimum 2.

Ports:
- clk  input  1  clock, rising edge.
- rst_async_n  input  1  asynchronous active-low reset.
- req  input  1  two-phase request; each toggle means din is valid (bundled data).
- din  input  WIDTH  data; stable from the req toggle until ack toggles to match.
- ack  output  1  two-phase acknowledge; toggles once per accepted word.
- dout  output  WIDTH  head-of-FIFO word.
- dout_valid  output  1  FIFO not empty.
- dout_ready  input  1  consumer accepts dout on a clk edge when dout_valid=1.
- level  output  clog2(DEPTH)+1  current occupancy.
- accepted_cnt  output  16  number of words accepted (see Optional Feature).

Behaviour:
- Reset (asynchronous, while rst_async_n=0) clears:
  - ack=0, synchroniser flops=0, internal phase bit ph=0.
  - Read/write pointers=0, level=0, dout_valid=0, dout=0, accepted_cnt=0.
  - FIFO storage need not be cleared.
- req must be 0 while in reset. Upstream shares rst_async_n.
- Synchroniser: req_s = req delayed by SYNC_STAGES flops. No logic between the flops.
- Pending condition: req_s != ph.
- Capture rule (one clk edge): if pending and level < DEPTH:
  - mem[wr_ptr] <= din; wr_ptr increments.
  - ph toggles; ack toggles; ack is registered and equals ph.
- din is sampled only on the capture edge. Bundled-data timing guarantees it has been stable for at least SYNC_STAGES cycles by then.
- Pop rule: dout_valid && dout_ready on an edge increments rd_ptr.
- dout = mem[rd_ptr], read combinationally from the register array (first-word fall-through). dout_valid = (level != 0).
- Latency: a req toggle is seen at req_s after SYNC_STAGES edges. The next edge captures the word. dout_valid rises after that edge when the FIFO was empty. The total is SYNC_STAGES+1 edges.
- Throughput: at most one word per handshake round trip, i.e. ≥ SYNC_STAGES+1 cycles plus upstream delay.
- Full (level==DEPTH):
  - No capture; ack is held, so upstream stalls naturally.
  - A pop in the same cycle does not enable a capture; the capture happens on the following edge.
- Empty: dout_valid=0, dout_ready is ignored, and pointers are unchanged.
- Simultaneous capture and pop with 0<level<DEPTH: both happen; level is unchanged.
- Pointers are clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. level = wr_ptr - rd_ptr.
- At most one capture per pending phase. ph toggling clears the pending condition until req toggles again.
- Reset mid-transfer: all state is cleared immediately, and any words in flight or buffered are lost. After release the block waits for a fresh req toggle from 0.

Optional Feature:
- Macro: TWO_PHASE_RX_FIFO_STATS_EN.
- Defined: accepted_cnt is a 16-bit counter.
  - It increments on each capture edge and wraps from 16'hFFFF to 0.
  - It is cleared by reset.
- Undefined: accepted_cnt is tied to 16'h0 and no counter flops are generated. The port list is identical in both cases.

Test Plan:
- Single word: with dout_ready=0, toggle req 0->1 with din=32'h1234_5678. Required: ack goes 0->1 exactly 3 edges later (SYNC_STAGES=2), dout_valid=1, dout=32'h1234_5678, level=1.
- Fill to full: with dout_ready=0, send 5 words 32'hA0..32'hA4 (DEPTH=4). Required: ack toggles 4 times, level=4, and the 5th req toggle stays pending with ack unchanged. Then pulse dout_ready for one cycle: 32'hA0 pops and the 5th word is captured one edge later; level returns to 4.
- Streaming: with dout_ready=1, drive 100 handshakes from a mousetrap-style upstream with incrementing data. Required: dout sequence is 0..99 in order, with no duplicates or drops; accepted_cnt=100 when TWO_PHASE_RX_FIFO_STATS_EN is defined, else 0.
- Wrap-around: run 3·DEPTH+1 pushes and pops interleaved. Required: ordering is preserved across the pointer wrap, and level never exceeds 4.
- Reset mid-operation: with level=3 and a req toggle pending, drop rst_async_n for 20ns. Required: ack=0, level=0, dout_valid=0 immediately (asynchronously). After release with req=0 and no toggle, no capture occurs.
- Counter wrap (STATS_EN): force accepted_cnt to 16'hFFFF, then perform one capture. Required: accepted_cnt=16'h0000.
